// File: rtl/axi_lite_interconnect_s2m.sv
// Single-master to multi-slave AXI-Lite demultiplexer. An address field selects the slave;
// indices with no slave behind them are answered locally with DECERR.
module axi_lite_interconnect_s2m #(
  parameter int unsigned NUM      = 4,
  parameter int unsigned ADDR_LSB = 12,
  parameter int unsigned ASIZE    = 32,
  parameter int unsigned DSIZE    = 32
) (
  input  logic                   clock,
  input  logic                   rst,
  // upstream port facing the master
  input  logic [ASIZE-1:0]       s00_axi_awaddr,
  input  logic                   s00_axi_awvalid,
  output logic                   s00_axi_awready,
  input  logic                   s00_axi_awlock,
  input  logic [DSIZE-1:0]       s00_axi_wdata,
  input  logic [DSIZE/8-1:0]     s00_axi_wstrb,
  input  logic                   s00_axi_wvalid,
  output logic                   s00_axi_wready,
  output logic [1:0]             s00_axi_bresp,
  output logic                   s00_axi_bvalid,
  input  logic                   s00_axi_bready,
  input  logic [ASIZE-1:0]       s00_axi_araddr,
  input  logic                   s00_axi_arvalid,
  output logic                   s00_axi_arready,
  input  logic                   s00_axi_arlock,
  output logic [DSIZE-1:0]       s00_axi_rdata,
  output logic [1:0]             s00_axi_rresp,
  output logic                   s00_axi_rvalid,
  input  logic                   s00_axi_rready,
  // downstream ports, slave k occupies slice k of each vector
  output logic [NUM*ASIZE-1:0]   m00_axi_awaddr,
  output logic [NUM-1:0]         m00_axi_awvalid,
  input  logic [NUM-1:0]         m00_axi_awready,
  output logic [NUM-1:0]         m00_axi_awlock,
  output logic [NUM*DSIZE-1:0]   m00_axi_wdata,
  output logic [NUM*DSIZE/8-1:0] m00_axi_wstrb,
  output logic [NUM-1:0]         m00_axi_wvalid,
  input  logic [NUM-1:0]         m00_axi_wready,
  input  logic [NUM*2-1:0]       m00_axi_bresp,
  input  logic [NUM-1:0]         m00_axi_bvalid,
  output logic [NUM-1:0]         m00_axi_bready,
  output logic [NUM*ASIZE-1:0]   m00_axi_araddr,
  output logic [NUM-1:0]         m00_axi_arvalid,
  input  logic [NUM-1:0]         m00_axi_arready,
  output logic [NUM-1:0]         m00_axi_arlock,
  input  logic [NUM*DSIZE-1:0]   m00_axi_rdata,
  input  logic [NUM*2-1:0]       m00_axi_rresp,
  input  logic [NUM-1:0]         m00_axi_rvalid,
  output logic [NUM-1:0]         m00_axi_rready
);

  localparam int unsigned NSIZE = (NUM <= 2) ? 1 : (NUM <= 4) ? 2 : (NUM <= 8) ? 3 :
                                  (NUM <= 16) ? 4 : 5;

  typedef enum logic [2:0] {WIdle, WAddr, WResp, WErr, WBerr} w_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData, RErr} r_state_e;

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic [ASIZE-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [NSIZE-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic             wlock_q, wlock_d, rlock_q, rlock_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [NSIZE-1:0] aw_idx, ar_idx;
  logic             aw_hit, ar_hit;
  logic [NUM-1:0]   wsel, rsel;
  logic             sel_awready, sel_wready, sel_bvalid, sel_arready, sel_rvalid;
  logic [1:0]       sel_bresp, sel_rresp;
  logic [DSIZE-1:0] sel_rdata;

  assign aw_idx = s00_axi_awaddr[ADDR_LSB +: NSIZE];
  assign ar_idx = s00_axi_araddr[ADDR_LSB +: NSIZE];
  assign aw_hit = 32'(aw_idx) < NUM;
  assign ar_hit = 32'(ar_idx) < NUM;

  // Out-of-range indices leave the select vectors all-zero, so no slave is touched.
  always_comb begin
    wsel        = '0;
    rsel        = '0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bresp   = '0;
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rresp   = '0;
    sel_rdata   = '0;
    for (int k = 0; k < NUM; k++) begin
      if (widx_q == NSIZE'(k)) begin
        wsel[k]     = 1'b1;
        sel_awready = m00_axi_awready[k];
        sel_wready  = m00_axi_wready[k];
        sel_bvalid  = m00_axi_bvalid[k];
        sel_bresp   = m00_axi_bresp[2*k +: 2];
      end
      if (ridx_q == NSIZE'(k)) begin
        rsel[k]     = 1'b1;
        sel_arready = m00_axi_arready[k];
        sel_rvalid  = m00_axi_rvalid[k];
        sel_rresp   = m00_axi_rresp[2*k +: 2];
        sel_rdata   = m00_axi_rdata[DSIZE*k +: DSIZE];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      waddr_q   <= '0;
      raddr_q   <= '0;
      widx_q    <= '0;
      ridx_q    <= '0;
      wlock_q   <= 1'b0;
      rlock_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      widx_q    <= widx_d;
      ridx_q    <= ridx_d;
      wlock_q   <= wlock_d;
      rlock_q   <= rlock_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    widx_d    = widx_q;
    wlock_d   = wlock_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (w_state_q)
      WIdle: begin
        if (s00_axi_awvalid) begin
          waddr_d   = s00_axi_awaddr;
          widx_d    = aw_idx;
          wlock_d   = s00_axi_awlock;
          w_state_d = aw_hit ? WAddr : WErr;
        end
      end
      WAddr: begin
        aw_done_d = aw_done_q | sel_awready;
        w_done_d  = w_done_q | (s00_axi_wvalid & sel_wready);
        if (aw_done_d && w_done_d) w_state_d = WResp;
      end
      WResp: begin
        if (sel_bvalid && s00_axi_bready) begin
          w_state_d = WIdle;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WErr:    if (s00_axi_wvalid) w_state_d = WBerr;
      WBerr:   if (s00_axi_bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    s00_axi_bresp   = '0;
    m00_axi_awvalid = '0;
    m00_axi_wvalid  = '0;
    m00_axi_bready  = '0;
    m00_axi_awlock  = '0;
    unique case (w_state_q)
      WIdle: s00_axi_awready = 1'b1;
      WAddr: begin
        m00_axi_awvalid = wsel & {NUM{~aw_done_q}};
        m00_axi_wvalid  = wsel & {NUM{s00_axi_wvalid & ~w_done_q}};
        s00_axi_wready  = sel_wready & ~w_done_q;
      end
      WResp: begin
        s00_axi_bvalid = sel_bvalid;
        s00_axi_bresp  = sel_bresp;
        m00_axi_bready = wsel & {NUM{s00_axi_bready}};
      end
      WErr: s00_axi_wready = 1'b1;
      WBerr: begin
        s00_axi_bvalid = 1'b1;
        s00_axi_bresp  = 2'b11;
      end
      default: ;
    endcase
    if (w_state_q != WIdle) m00_axi_awlock = wsel & {NUM{wlock_q}};
  end

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    ridx_d    = ridx_q;
    rlock_d   = rlock_q;
    unique case (r_state_q)
      RIdle: begin
        if (s00_axi_arvalid) begin
          raddr_d   = s00_axi_araddr;
          ridx_d    = ar_idx;
          rlock_d   = s00_axi_arlock;
          r_state_d = ar_hit ? RAddr : RErr;
        end
      end
      RAddr:   if (sel_arready) r_state_d = RData;
      RData:   if (sel_rvalid && s00_axi_rready) r_state_d = RIdle;
      RErr:    if (s00_axi_rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    s00_axi_rdata   = '0;
    s00_axi_rresp   = '0;
    m00_axi_arvalid = '0;
    m00_axi_rready  = '0;
    m00_axi_arlock  = '0;
    unique case (r_state_q)
      RIdle: s00_axi_arready = 1'b1;
      RAddr: m00_axi_arvalid = rsel;
      RData: begin
        s00_axi_rvalid = sel_rvalid;
        s00_axi_rdata  = sel_rdata;
        s00_axi_rresp  = sel_rresp;
        m00_axi_rready = rsel & {NUM{s00_axi_rready}};
      end
      RErr: begin
        s00_axi_rvalid = 1'b1;
        s00_axi_rresp  = 2'b11;
      end
      default: ;
    endcase
    if (r_state_q != RIdle) m00_axi_arlock = rsel & {NUM{rlock_q}};
  end

  // Address and write data are broadcast; only the valids qualify them per slave.
  assign m00_axi_awaddr = {NUM{waddr_q}};
  assign m00_axi_araddr = {NUM{raddr_q}};
  assign m00_axi_wdata  = {NUM{s00_axi_wdata}};
  assign m00_axi_wstrb  = {NUM{s00_axi_wstrb}};

endmodule

// File: doc/axi_lite_interconnect_s2m.md
# axi_lite_interconnect_S2M

Single-master to multi-slave AXI-Lite demultiplexer. It takes one upstream AXI-Lite master and routes each transaction to one of NUM downstream slaves, chosen by an address field. The write and read channels run independently, each with one transaction outstanding. Addresses that decode to no slave get a locally generated DECERR response. It is the counterpart of the M2S interconnect and sits between a bus master (CPU bridge or register-access engine) and a set of register-bank slaves.

## Interface
Parameters:
- NUM, 4, number of downstream slaves (2..32).
- ADDR_LSB, 12, lowest bit of the slave-select field. Slave index = s00.axi_awaddr/araddr[ADDR_LSB +: NSIZE].
- NSIZE is derived, not set by the user: 1 for NUM≤2, 2 for ≤4, 3 for ≤8, 4 for ≤16, otherwise 5.

Ports:
- clock, input, 1, the single clock for all logic. The interfaces' axi_aclk is not used internally.
- rst, input, 1, reset. Synchronous and active-high. The interfaces' axi_aresetn is ignored.
- s00, axi_lite_inf.slaver, interface, upstream port facing the master.
- m00[NUM-1:0], axi_lite_inf.master, interface array, downstream ports facing the slaves. ASIZE and DSIZE are the same as on s00.

## Operation
- Write FSM states: W_IDLE, W_ADDR, W_RESP, W_ERR, W_BERR.
  - W_IDLE: s00.axi_awready = 1. On awvalid, register the address, the index widx and the awlock.
    - If widx < NUM, go to W_ADDR.
    - Otherwise go to W_ERR.
  - W_ADDR: m00[widx].axi_awvalid is asserted from the register and held until awready, which sets aw_done.
    - The W channel passes straight through: m00[widx].wvalid/wdata = s00.wvalid/wdata, and s00.wready = m00[widx].wready.
    - A W handshake sets w_done and blocks any further W beat.
    - When aw_done and w_done are both set, go to W_RESP.
  - W_RESP: s00.bvalid/bresp = m00[widx].bvalid/bresp, and m00[widx].bready = s00.bready. On the handshake, go to W_IDLE and clear both flags.
  - W_ERR: s00.wready = 1 to absorb one beat, which is dropped. Then go to W_BERR.
  - W_BERR: s00.bvalid = 1 and bresp = 2'b11, held until bready. Then go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA, R_ERR.
  - R_IDLE: arready = 1. Register araddr, ridx and arlock.
  - R_ADDR: m00[ridx].arvalid is held until arready. Then go to R_DATA.
  - R_DATA: rvalid/rdata pass through from m00[ridx], and rready passes back. On the handshake, go to R_IDLE.
  - R_ERR: s00.rvalid = 1 and rdata = '0, held until rready. Then go to R_IDLE.
- Non-selected slave ports always see awvalid, wvalid, arvalid, bready and rready = 0.
- axi_awlock/axi_arlock are forwarded, as registered values, only to the selected slave while its FSM is outside IDLE. All other slaves see 0.
- wdata presented before awvalid is stalled (wready = 0 in W_IDLE). The W beat is never reordered ahead of its address.

## Timing
- Reset values:
  - Both FSMs in IDLE; indices 0; flags 0.
  - On s00: awready = 1 and arready = 1 (IDLE), wready = 0, bvalid = 0, rvalid = 0, bresp = 0, rdata = 0.
  - On every m00[k]: all valid and ready outputs 0, locks 0.
- Address latency: the s00 AW/AR handshake at cycle N gives m00 awvalid/arvalid asserted at N+1 (registered).
- W, B and R paths in their pass-through states add zero cycles of combinational latency.
- awready and arready are low from the cycle after acceptance until the return to IDLE. Back-to-back writes therefore have a minimum spacing of 3 cycles with a zero-wait slave.
- The write and read FSMs are fully independent. Simultaneous AW and AR to the same or different slaves are both accepted in the same cycle.
- DECERR path: bvalid asserts one cycle after the W handshake; rvalid asserts one cycle after the AR handshake.
- rst asserted in any state returns both FSMs to IDLE on the next edge and drops all valids. In-flight transactions are abandoned; no response is generated.
- ADDR_LSB + NSIZE must be ≤ ASIZE. The upper NSIZE-wide index values ≥ NUM always decode to DECERR.

## Test plan
- Write routing (NUM=4, ADDR_LSB=12): AW 0x2010, W 0xA5A5A5A5 → m00[2] sees awaddr 0x2010 one cycle later and wdata 0xA5A5A5A5; s00 bresp = 00; m00[0,1,3] stay idle.
- Read with backpressure: AR 0x1004, m00[1] holds arready low 3 cycles, returns rdata 0x12345678, s00.rready low 2 cycles → s00 gets 0x12345678 exactly once, and the m00[1] rvalid handshake completes with the s00 handshake.
- DECERR (NUM=3): write to 0x3000 → bresp = 2'b11; read of 0x3000 → rvalid with rdata = 0. No m00 valid is asserted in either case.
- W before AW: wvalid driven 4 cycles ahead of awvalid → wready stays 0 until W_ADDR, then one beat is transferred. The write completes correctly.
- Concurrency: same-cycle write to slave 0 and read from slave 3 → both complete, with no cross-traffic on m00[1] or m00[2].
- Reset mid-transaction: rst for 1 cycle while in W_ADDR with awvalid high → next cycle all m00 valids are 0, FSMs are in IDLE, and the next write completes normally.
